// File: rtl/clock_ratio_meter.sv
// Measures the edge-to-edge interval of a slow square wave in system-clock cycles and reports it as a ratio.
// Define CLOCK_RATIO_METER_SYNC_EN to put a 2-flop synchronizer in front of sig_in.
`timescale 1ns/1ps
module clock_ratio_meter #(
  parameter int          CNT_W      = 32,
  parameter logic [31:0] TIMEOUT    = 32'd1048576,
  parameter int          LOCK_COUNT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] ratio,
  output logic             ratio_valid,
  output logic             locked,
  output logic             timeout,
  output logic [1:0]       state
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  localparam int                MATCH_W     = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [MATCH_W-1:0] LOCK_M     = MATCH_W'(LOCK_COUNT);
  localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);

  logic               s;
  logic               s_prev;
  logic [CNT_W-1:0]   cnt;
  logic [MATCH_W-1:0] match;
  logic               edge_seen;
  logic               active;
  logic               timeout_hit;
  logic [MATCH_W-1:0] match_next;

`ifdef CLOCK_RATIO_METER_SYNC_EN
  logic sync_meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= 1'b0;
      s         <= 1'b0;
    end else begin
      sync_meta <= sig_in;
      s         <= sync_meta;
    end
  end
`else
  always_ff @(posedge clock) begin
    if (reset) s <= 1'b0;
    else       s <= sig_in;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) s_prev <= 1'b0;
    else       s_prev <= s;
  end

  // match == 0 marks the first sample since IDLE, which can never count as a repeat.
  always_comb begin
    edge_seen   = s ^ s_prev;
    active      = (state != IDLE);
    timeout_hit = active && !edge_seen && (cnt == TIMEOUT_CNT);
    match_next  = MATCH_ONE;
    if ((match != '0) && (cnt == ratio)) begin
      match_next = (match == LOCK_M) ? LOCK_M : match + MATCH_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      match       <= '0;
      ratio       <= '0;
      ratio_valid <= 1'b0;
      locked      <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      ratio_valid <= 1'b0;
      timeout     <= 1'b0;

      // In IDLE the counter freezes so a lost signal does not keep re-triggering.
      if (edge_seen) cnt <= CNT_ONE;
      else if (active && (cnt != TIMEOUT_CNT)) cnt <= cnt + CNT_ONE;

      if (edge_seen) begin
        if (!active) begin
          state <= MEASURE;
        end else begin
          ratio       <= cnt;
          ratio_valid <= 1'b1;
          match       <= match_next;
          state       <= (match_next == LOCK_M) ? LOCKED : MEASURE;
          locked      <= (match_next == LOCK_M);
        end
      end else if (timeout_hit) begin
        timeout <= 1'b1;
        state   <= IDLE;
        match   <= '0;
        locked  <= 1'b0;
      end
    end
  end

endmodule
